// File: rtl/select_control_pkg.sv
// rtl/select_control_pkg.sv - shared constants and helpers for the time/alarm select and edit block
//
// Holds the display digit byte field positions, the BCD digit limits used
// when editing, the editable cursor index range and the blink half-period.
// digit_max() returns the wrap limit of the buffer digit under the cursor.
package select_control_pkg;

  // Display digit byte layout
  localparam int DIG_LSB    = 0;
  localparam int DIG_W      = 4;
  localparam int BIT_BLANK  = 4;
  localparam int BIT_PM     = 5;
  localparam int BIT_RSVD   = 6;
  localparam int BIT_CURSOR = 7;

  // BCD digit limits while editing
  localparam logic [3:0] HH_TENS_MAX     = 4'd2;
  localparam logic [3:0] HH_UNITS_MAX    = 4'd9;
  localparam logic [3:0] HH_UNITS_MAX_20 = 4'd3;
  localparam logic [3:0] MS_TENS_MAX     = 4'd5;
  localparam logic [3:0] MS_UNITS_MAX    = 4'd9;

  // Editable cursor range (digit 7 = HH tens ... digit 2 = SS units)
  localparam logic [3:0] IDX_MIN = 4'd2;
  localparam logic [3:0] IDX_MAX = 4'd7;

  // Cursor blink half-period in CP_1KHz cycles (2 Hz)
  localparam int BLINK_HALF = 250;

  // Largest legal value of the digit at idx; HH units shrinks to 3 in the 20s.
  function automatic logic [3:0] digit_max(input logic [3:0] idx,
                                           input logic [3:0] hh_tens);
    logic [3:0] mx;
    case (idx)
      4'd7:       mx = HH_TENS_MAX;
      4'd6:       mx = (hh_tens == 4'd2) ? HH_UNITS_MAX_20 : HH_UNITS_MAX;
      4'd5, 4'd3: mx = MS_TENS_MAX;
      default:    mx = MS_UNITS_MAX;
    endcase
    return mx;
  endfunction

endpackage

// File: rtl/select_control_btn_edge.sv
// rtl/select_control_btn_edge.sv - registered rising-edge detector for one level button
//
// Ports:
//   clk   - sampling clock (rising edge)
//   rst   - asynchronous active-high reset, clears both registers
//   btn   - level button input
//   pulse - one-cycle registered pulse after each 0->1 transition of btn
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= btn & ~prev;
    end
  end

endmodule

// File: rtl/select_control.sv
// rtl/select_control.sv - clock/alarm display selection, digit-wise time editor and apply strobe
//
// Optional feature macro: SELECT_BLINK_EN (cursor digit blinks at 2 Hz while editing).
//
// Ports:
//   CP_1KHz      - sole clock, rising edge
//   _CR          - asynchronous active-high reset
//   mode         - 0 = clock source, 1 = alarm source
//   adjust       - edit enable
//   time_mode    - 0 = 24 h display, 1 = 12 h display
//   left/right/up/down/apply - level buttons, edge detected internally
//   show_time    - BCD {HH,MM,SS,CC} clock value
//   alarm_time   - BCD {HH,MM,SS,CC} alarm value
//   display_time - 8 digit bytes, byte k = digit k: [3:0] BCD, [4] blank, [5] PM, [6] 0, [7] cursor
//   set_time     - last applied edit buffer (24 h BCD)
//   index        - cursor digit, 2..7
//   PE           - one-cycle load strobe accompanying a new set_time
module select_control
  import select_control_pkg::*;
(
  input  logic        CP_1KHz,
  input  logic        _CR,
  input  logic        mode,
  input  logic        adjust,
  input  logic        time_mode,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        apply,
  input  logic [31:0] show_time,
  input  logic [31:0] alarm_time,
  output logic [63:0] display_time,
  output logic [31:0] set_time,
  output logic [3:0]  index,
  output logic        PE
);

  logic p_left, p_right, p_up, p_down, p_apply;

  btn_edge u_left  (.clk(CP_1KHz), .rst(_CR), .btn(left),  .pulse(p_left));
  btn_edge u_right (.clk(CP_1KHz), .rst(_CR), .btn(right), .pulse(p_right));
  btn_edge u_up    (.clk(CP_1KHz), .rst(_CR), .btn(up),    .pulse(p_up));
  btn_edge u_down  (.clk(CP_1KHz), .rst(_CR), .btn(down),  .pulse(p_down));
  btn_edge u_apply (.clk(CP_1KHz), .rst(_CR), .btn(apply), .pulse(p_apply));

  logic [31:0] edit_buf, buf_nxt, set_nxt, src;
  logic [3:0]  index_nxt, cur, mx, nd;
  logic        pe_nxt;
  logic        adj_q, mode_q, hist_valid, load;

  assign src = mode ? alarm_time : show_time;

  // hist_valid keeps the first cycle after reset from looking like an
  // adjust edge, so a held adjust does not reload a discarded buffer.
  assign load = hist_valid & adjust & (~adj_q | (mode ^ mode_q));

  always_comb begin
    buf_nxt   = edit_buf;
    index_nxt = index;
    set_nxt   = set_time;
    pe_nxt    = 1'b0;
    cur       = edit_buf[{index[2:0], 2'b00} +: 4];
    mx        = digit_max(index, edit_buf[31:28]);
    nd        = cur;
    if (load) begin
      buf_nxt   = {src[31:8], 8'h00};
      index_nxt = IDX_MAX;
    end else if (adjust) begin
      if (p_apply) begin
        set_nxt = edit_buf;
        pe_nxt  = 1'b1;
      end else if (p_up | p_down) begin
        // up and down together consume the press without changing anything
        if (p_up ^ p_down) begin
          if (p_up) nd = (cur >= mx) ? 4'd0 : cur + 4'd1;
          else      nd = (cur == 4'd0 || cur > mx) ? mx : cur - 4'd1;
          buf_nxt[{index[2:0], 2'b00} +: 4] = nd;
          if (index == IDX_MAX && nd == 4'd2 && buf_nxt[27:24] > HH_UNITS_MAX_20)
            buf_nxt[27:24] = HH_UNITS_MAX_20;
        end
      end else if (p_left ^ p_right) begin
        if (p_left) index_nxt = (index == IDX_MAX) ? IDX_MIN : index + 4'd1;
        else        index_nxt = (index == IDX_MIN) ? IDX_MAX : index - 4'd1;
      end
    end
  end

  always_ff @(posedge CP_1KHz or posedge _CR) begin
    if (_CR) begin
      edit_buf   <= '0;
      index      <= IDX_MAX;
      set_time   <= '0;
      PE         <= 1'b0;
      adj_q      <= 1'b0;
      mode_q     <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      edit_buf   <= buf_nxt;
      index      <= index_nxt;
      set_time   <= set_nxt;
      PE         <= pe_nxt;
      adj_q      <= adjust;
      mode_q     <= mode;
      hist_valid <= 1'b1;
    end
  end

  logic blink_phase;

`ifdef SELECT_BLINK_EN
  logic [7:0] blink_cnt;

  always_ff @(posedge CP_1KHz or posedge _CR) begin
    if (_CR) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!adjust || index_nxt != index) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == 8'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 8'd1;
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

  // Display path: 12 h conversion touches only the shown hours.
  logic [31:0] view;
  logic [6:0]  hh_bin, hh_12;
  logic [3:0]  hh_t, hh_u, dig;
  logic        pm;

  assign view = adjust ? edit_buf : src;

  always_comb begin
    hh_bin = 7'(view[31:28]) * 7'd10 + 7'(view[27:24]);
    hh_12  = (hh_bin == 7'd0) ? 7'd12 : (hh_bin > 7'd12) ? hh_bin - 7'd12 : hh_bin;
    hh_t   = 4'(hh_12 / 7'd10);
    hh_u   = 4'(hh_12 % 7'd10);
    pm     = time_mode & (hh_bin >= 7'd12);
    display_time = '0;
    dig    = '0;
    for (int k = 0; k < 8; k++) begin
      dig = view[k*4 +: 4];
      if (time_mode && k == 7) dig = hh_t;
      if (time_mode && k == 6) dig = hh_u;
      display_time[k*8 + DIG_LSB +: DIG_W] = dig;
      display_time[k*8 + BIT_BLANK]  = (k == 7 && time_mode && dig == 4'd0) |
                                       (adjust && index == 4'(k) && blink_phase);
      display_time[k*8 + BIT_PM]     = pm && (k >= 6);
      display_time[k*8 + BIT_RSVD]   = 1'b0;
      display_time[k*8 + BIT_CURSOR] = adjust && index == 4'(k);
    end
  end

endmodule

// File: tb/tb_select_control.sv
// tb/tb_select_control.sv - directed self-checking bench for select_control
module tb_select_control;

  logic        CP_1KHz = 1'b0;
  logic        _CR = 1'b1;
  logic        mode = 1'b0, adjust = 1'b0, time_mode = 1'b0;
  logic        left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, apply = 1'b0;
  logic [31:0] show_time = '0, alarm_time = '0;
  logic [63:0] display_time;
  logic [31:0] set_time;
  logic [3:0]  index;
  logic        PE;

  int errors = 0;
  int checks = 0;

  select_control dut (
    .CP_1KHz(CP_1KHz), ._CR(_CR), .mode(mode), .adjust(adjust), .time_mode(time_mode),
    .left(left), .right(right), .up(up), .down(down), .apply(apply),
    .show_time(show_time), .alarm_time(alarm_time),
    .display_time(display_time), .set_time(set_time), .index(index), .PE(PE)
  );

  always #5 CP_1KHz = ~CP_1KHz;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CP_1KHz);
      #1;
    end
  endtask

  // m = {apply, up, down, left, right}
  task automatic press(input logic [4:0] m);
    {apply, up, down, left, right} = m;
    tick(2);
    {apply, up, down, left, right} = 5'b0;
    tick(2);
  endtask

  task automatic apply_count(output int n);
    n = 0;
    apply = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) apply = 1'b0;
      n += int'(PE);
    end
  endtask

  localparam logic [4:0] B_APPLY = 5'b10000, B_UP = 5'b01000, B_DOWN = 5'b00100,
                         B_LEFT = 5'b00010, B_RIGHT = 5'b00001;

  int  n;
  int  toggles;
  logic prev_b;

  initial begin
    tick(2);
    check_eq("rst_set_time", 64'(set_time), 64'h0);
    check_eq("rst_pe", 64'(PE), 64'h0);
    check_eq("rst_index", 64'(index), 64'd7);
    check_eq("rst_display", display_time, 64'h0);
    _CR = 1'b0;
    tick(2);

    // 24 h clock display, combinational
    for (int s = 0; s < 4; s++) begin
      show_time = 32'h10360000 | (32'(s) << 8);
      #1;
      check_eq("disp24", display_time, 64'h01_00_03_06_00_00_00_00 | (64'(s) << 16));
    end
    check_eq("idle_pe", 64'(PE), 64'h0);
    check_eq("idle_set_time", 64'(set_time), 64'h0);

    // 12 h conversion
    time_mode = 1'b1;
    show_time = 32'h13450000; #1;
    check_eq("h12_13", display_time, 64'h30_21_04_05_00_00_00_00);
    show_time = 32'h00050000; #1;
    check_eq("h12_00", display_time, 64'h01_02_00_05_00_00_00_00);
    show_time = 32'h12000000; #1;
    check_eq("h12_12", display_time, 64'h21_22_00_00_00_00_00_00);
    show_time = 32'h09000000; #1;
    check_eq("h12_09", display_time, 64'h10_09_00_00_00_00_00_00);
    time_mode = 1'b0;

    // edit from clock source
    show_time = 32'h10360000;
    tick();
    adjust = 1'b1;
    tick(2);
    check_eq("load_index", 64'(index), 64'd7);
    check_eq("load_disp", display_time, 64'h81_00_03_06_00_00_00_00);
    show_time = 32'h22222222; #1;
    check_eq("edit_ignores_src", display_time, 64'h81_00_03_06_00_00_00_00);
    press(B_UP);
    check_eq("up_hh20", display_time, 64'h82_00_03_06_00_00_00_00);
    press(B_UP);
    check_eq("up_wrap0", display_time, 64'h80_00_03_06_00_00_00_00);
    press(B_UP | B_DOWN);
    check_eq("up_down_nop", display_time, 64'h80_00_03_06_00_00_00_00);
    press(B_LEFT);
    check_eq("left_wrap", 64'(index), 64'd2);
    check_eq("left_disp", display_time, 64'h00_00_03_06_00_80_00_00);
    press(B_RIGHT);
    check_eq("right_wrap", 64'(index), 64'd7);
    press(B_UP);
    press(B_RIGHT);
    press(B_DOWN);
    check_eq("down_wrap9", display_time, 64'h01_89_03_06_00_00_00_00);
    press(B_LEFT);
    press(B_UP);
    check_eq("clamp23", display_time, 64'h82_03_03_06_00_00_00_00);
    press(B_UP | B_APPLY);
    check_eq("apply_prio_set", 64'(set_time), 64'h23360000);
    check_eq("apply_prio_buf", display_time, 64'h82_03_03_06_00_00_00_00);
    apply_count(n);
    check_eq("pe_once", 64'(n), 64'd1);
    check_eq("set_time", 64'(set_time), 64'h23360000);

    // alarm source, abort and ignored apply
    adjust = 1'b0; mode = 1'b1; alarm_time = 32'h06300059;
    tick(2);
    check_eq("alarm_disp", display_time, 64'h00_06_03_00_00_00_05_09);
    check_eq("abort_set_time", 64'(set_time), 64'h23360000);
    adjust = 1'b1;
    tick(2);
    check_eq("alarm_load", display_time, 64'h80_06_03_00_00_00_00_00);
    press(B_RIGHT);
    check_eq("right_6", 64'(index), 64'd6);
    mode = 1'b0; show_time = 32'h12345678;
    tick(2);
    check_eq("mode_reload_idx", 64'(index), 64'd7);
    check_eq("mode_reload", display_time, 64'h81_02_03_04_05_06_00_00);
    adjust = 1'b0;
    tick();
    apply_count(n);
    check_eq("apply_idle_pe", 64'(n), 64'd0);
    check_eq("apply_idle_set", 64'(set_time), 64'h23360000);

    // reset mid-edit
    adjust = 1'b1;
    tick(2);
    _CR = 1'b1;
    tick();
    _CR = 1'b0;
    tick(3);
    check_eq("mid_rst_disp", display_time, 64'h80_00_00_00_00_00_00_00);
    check_eq("mid_rst_set", 64'(set_time), 64'h0);
    adjust = 1'b0;
    tick(2);
    adjust = 1'b1;
    tick(2);
    check_eq("fresh_reload", display_time, 64'h81_02_03_04_05_06_00_00);

    // cursor blink on byte 7
    adjust = 1'b0;
    tick(2);
    adjust = 1'b1;
    toggles = 0;
    prev_b  = 1'b0;
    for (int i = 0; i < 1010; i++) begin
      tick();
      if (display_time[60] !== prev_b) toggles++;
      prev_b = display_time[60];
    end
`ifdef SELECT_BLINK_EN
    check_eq("blink_toggles", 64'(toggles), 64'd4);
`else
    check_eq("blink_toggles", 64'(toggles), 64'd0);
    check_eq("blink_bit", 64'(display_time[60]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
